// File: rtl/pa_clic_cpuif_pkg.sv
// Shared definitions for the CLIC CPU-side interface (multi-cycle CLIC clock).
//   ID_WIDTH_DEF / IL_WIDTH_DEF : default interrupt ID and level widths.
//   exit_ptr_w()                : pointer width for an exit queue of a given depth.
//   exit_entry_t                : one queued interrupt-exit record.
package pa_clic_cpuif_pkg;

    localparam int ID_WIDTH_DEF = 12;
    localparam int IL_WIDTH_DEF = 8;

    // Pointer width for a queue of 'depth' entries; never narrower than 1 bit.
    function automatic int exit_ptr_w(input int depth);
        if (depth <= 1) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

    // Queued exit: the ID of the interrupt being left. Stored at the default
    // ID width; narrower top-level IDs are zero-extended on the way in.
    typedef struct packed {
        logic [ID_WIDTH_DEF-1:0] id;
    } exit_entry_t;

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate.
//   clk_in             : free-running clock.
//   global_en/module_en/local_en/external_en : enable terms, combined as
//                        (global_en & (module_en | local_en)) | external_en.
//   pad_yy_icg_scan_en : forces the clock on during scan.
//   clk_out            : gated clock.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_s;
    logic en_lat_r;

    assign clk_en_s = (global_en & (module_en | local_en)) | external_en;

    // Enable latch, transparent while the clock is low so clk_out is glitch-free.
    always_latch begin
        if (!clk_in) begin
            en_lat_r <= clk_en_s | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & en_lat_r;

endmodule

// File: rtl/pa_clic_cpuif_exit_fifo.sv
// Interrupt-exit queue between the CPU and a slower CLIC.
//   clk, rst_n : (gated) CPU clock, async active-low reset.
//   push       : enqueue push_data this cycle.
//   pop        : dequeue the head; ignored when the queue is empty.
//   head       : oldest entry (valid when !empty).
//   empty/full : occupancy flags; last = exactly one entry held.
//   ovf        : sticky, set when a push finds the queue full with no pop.
// A push and a pop in the same cycle are both honoured, even when full.
module pa_clic_cpuif_exit_fifo
    import pa_clic_cpuif_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  exit_entry_t push_data,
    input  logic        pop,
    output exit_entry_t head,
    output logic        empty,
    output logic        full,
    output logic        last,
    output logic        ovf
);

    localparam int              PW         = exit_ptr_w(DEPTH);
    localparam logic [PW:0]     DEPTH_V    = DEPTH[PW:0];
    localparam logic [PW:0]     ONE_V      = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]     LAST_IDX_V = DEPTH_V - ONE_V;

    exit_entry_t   mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW:0]   count_r;
    logic          ovf_r;

    logic          pop_ok_s;
    logic          push_ok_s;
    logic [PW:0]   tail_raw_s;
    logic [PW:0]   tail_wrap_s;
    logic [PW-1:0] wr_idx_s;
    logic [PW-1:0] head_nxt_s;

    assign empty = (count_r == {(PW+1){1'b0}});
    assign full  = (count_r == DEPTH_V);
    assign last  = (count_r == ONE_V);
    assign ovf   = ovf_r;
    assign head  = mem_r[head_r];

    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Tail slot and next head, both wrapping modulo DEPTH (DEPTH need not be 2^n).
    always_comb begin
        tail_raw_s = {1'b0, head_r} + count_r;
        if (tail_raw_s >= DEPTH_V) begin
            tail_wrap_s = tail_raw_s - DEPTH_V;
        end else begin
            tail_wrap_s = tail_raw_s;
        end
        wr_idx_s = tail_wrap_s[PW-1:0];
        if ({1'b0, head_r} == LAST_IDX_V) begin
            head_nxt_s = {PW{1'b0}};
        end else begin
            head_nxt_s = head_r + PW'(1'b1);
        end
    end

    // Queue storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
            ovf_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_idx_s] <= push_data;
            end
            if (pop_ok_s) begin
                head_r <= head_nxt_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_V;
                2'b01:   count_r <= count_r - ONE_V;
                default: count_r <= count_r;
            endcase
            if (push && full && !pop_ok_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pa_clic_cpuif_mcycle.sv
// CPU-side interface of a CLIC running on a divided clock.
// clic_clk_en marks the CPU cycle that ends with a CLIC clock edge.
//   Inputs : forever_cpuclk, cpurst_b (async active-low), pad_yy_icg_scan_en,
//            clic_clk_en, arbiter result clic_int_hv/id/il_raw/priv,
//            cpu_clic_curid + cpu_clic_int_exit (exit pulse from the core).
//   Outputs: clic_cpu_int_hv/id/il/priv to the core (il gated),
//            cpu_int_exit (exit queue non-empty), ctrl_kid_ack_int (one-hot
//            ack of the head exit ID), cpuif_exit_ovf (sticky overflow).
// Build option CLIC_CPUIF_OUT_FLOP_EN registers hv/id/il/priv (one extra cycle).
module pa_clic_cpuif_mcycle
    import pa_clic_cpuif_pkg::*;
#(
    parameter int CLICINTNUM = 64,
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int IL_WIDTH   = IL_WIDTH_DEF,
    parameter int EXIT_DEPTH = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  clic_clk_en,
    input  logic                  clic_int_hv,
    input  logic [ID_WIDTH-1:0]   clic_int_id,
    input  logic [IL_WIDTH-1:0]   clic_int_il_raw,
    input  logic [1:0]            clic_int_priv,
    input  logic [ID_WIDTH-1:0]   cpu_clic_curid,
    input  logic                  cpu_clic_int_exit,
    output logic                  clic_cpu_int_hv,
    output logic [ID_WIDTH-1:0]   clic_cpu_int_id,
    output logic [IL_WIDTH-1:0]   clic_cpu_int_il,
    output logic [1:0]            clic_cpu_int_priv,
    output logic                  cpu_int_exit,
    output logic [CLICINTNUM-1:0] ctrl_kid_ack_int,
    output logic                  cpuif_exit_ovf
);

    logic                  cpuif_clk;
    logic                  cpuif_clk_en_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  fifo_last_s;
    logic                  fifo_ovf_s;
    exit_entry_t           fifo_head_s;
    exit_entry_t           push_entry_s;
    logic [ID_WIDTH-1:0]   head_id_s;
    logic                  pop_s;
    logic                  stale_hold_r;
    logic                  int_en_r;
    logic                  stale_s;
    logic                  if_en_s;
    logic [IL_WIDTH-1:0]   il_gated_s;
    logic [IL_WIDTH-1:0]   il_fwd_s;
    logic [CLICINTNUM-1:0] ack_s;

    // The clock may stop only when nothing can change: no level pending,
    // no queued or incoming exit, and no stale/window state to retire.
    assign cpuif_clk_en_s = (|clic_int_il_raw) | ~fifo_empty_s | stale_hold_r | int_en_r
                          | cpu_clic_int_exit | (clic_clk_en & ~fifo_empty_s);

    gated_clk_cell u_cpuif_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (1'b0),
        .local_en           (cpuif_clk_en_s),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (cpuif_clk)
    );

    // The CLIC samples the head exactly at its clock edge.
    assign pop_s = clic_clk_en & ~fifo_empty_s;

    // Widen/narrow between the top-level ID width and the queue entry width.
    always_comb begin
        push_entry_s    = '0;
        push_entry_s.id = ID_WIDTH_DEF'(cpu_clic_curid);
        head_id_s       = ID_WIDTH'(fifo_head_s.id);
    end

    pa_clic_cpuif_exit_fifo #(
        .DEPTH (EXIT_DEPTH)
    ) u_exit_fifo (
        .clk       (cpuif_clk),
        .rst_n     (cpurst_b),
        .push      (cpu_clic_int_exit),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .last      (fifo_last_s),
        .ovf       (fifo_ovf_s)
    );

    // After the last exit is sampled, the arbiter output is still the
    // pre-exit result until the CLIC's next edge re-arbitrates.
    always_ff @(posedge cpuif_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stale_hold_r <= 1'b0;
        end else if (pop_s && fifo_last_s && !cpu_clic_int_exit) begin
            stale_hold_r <= 1'b1;
        end else if (clic_clk_en) begin
            stale_hold_r <= 1'b0;
        end else begin
            stale_hold_r <= stale_hold_r;
        end
    end

    assign stale_s = ~fifo_empty_s | stale_hold_r | cpu_clic_int_exit;

    // A level is not newly accepted in an edge cycle (it may change at the
    // edge), but one already forwarded keeps flowing through it.
    assign if_en_s    = ~clic_clk_en | int_en_r;
    assign il_gated_s = clic_int_il_raw & {IL_WIDTH{if_en_s & ~stale_s}};

`ifdef CLIC_CPUIF_OUT_FLOP_EN
    logic                hv_r;
    logic [ID_WIDTH-1:0] id_r;
    logic [IL_WIDTH-1:0] il_r;
    logic [1:0]          priv_r;

    // Output register stage; hv/id/priv only matter while il is non-zero,
    // which keeps the gated clock running.
    always_ff @(posedge cpuif_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            hv_r   <= 1'b0;
            id_r   <= {ID_WIDTH{1'b0}};
            il_r   <= {IL_WIDTH{1'b0}};
            priv_r <= 2'b00;
        end else begin
            hv_r   <= clic_int_hv;
            id_r   <= clic_int_id;
            il_r   <= il_gated_s;
            priv_r <= clic_int_priv;
        end
    end

    assign clic_cpu_int_hv   = hv_r;
    assign clic_cpu_int_id   = id_r;
    assign clic_cpu_int_il   = il_r;
    assign clic_cpu_int_priv = priv_r;
    assign il_fwd_s          = il_r;
`else
    assign clic_cpu_int_hv   = clic_int_hv;
    assign clic_cpu_int_id   = clic_int_id;
    assign clic_cpu_int_il   = il_gated_s;
    assign clic_cpu_int_priv = clic_int_priv;
    assign il_fwd_s          = il_gated_s;
`endif

    // Window flag: remembers that a level reached the core last cycle.
    always_ff @(posedge cpuif_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            int_en_r <= 1'b0;
        end else if (cpu_clic_int_exit) begin
            int_en_r <= 1'b0;
        end else begin
            int_en_r <= |il_fwd_s;
        end
    end

    // One-hot ack of the head exit; IDs outside the source range ack nothing.
    always_comb begin
        ack_s = {CLICINTNUM{1'b0}};
        for (int i = 0; i < CLICINTNUM; i++) begin
            if (!fifo_empty_s && (32'(head_id_s) == i)) begin
                ack_s[i] = 1'b1;
            end else begin
                ack_s[i] = 1'b0;
            end
        end
    end

    assign cpu_int_exit     = ~fifo_empty_s;
    assign ctrl_kid_ack_int = ack_s;
    assign cpuif_exit_ovf   = fifo_ovf_s;

endmodule

// File: tb/tb_pa_clic_cpuif_mcycle.sv
// Self-checking bench for pa_clic_cpuif_mcycle (default build, EXIT_DEPTH=2).
module tb_pa_clic_cpuif_mcycle;

    localparam int NSRC  = 64;
    localparam int DEPTH = 2;

    logic        clk;
    logic        cpurst_b;
    logic        scan_en;
    logic        ce;
    logic        hv_i;
    logic [11:0] id_i;
    logic [7:0]  raw;
    logic [1:0]  priv_i;
    logic [11:0] curid;
    logic        ex;
    logic        hv_o;
    logic [11:0] id_o;
    logic [7:0]  il_o;
    logic [1:0]  priv_o;
    logic        xo;
    logic [63:0] ack;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    pa_clic_cpuif_mcycle #(
        .CLICINTNUM (NSRC),
        .ID_WIDTH   (12),
        .IL_WIDTH   (8),
        .EXIT_DEPTH (DEPTH)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (cpurst_b),
        .pad_yy_icg_scan_en (scan_en),
        .clic_clk_en        (ce),
        .clic_int_hv        (hv_i),
        .clic_int_id        (id_i),
        .clic_int_il_raw    (raw),
        .clic_int_priv      (priv_i),
        .cpu_clic_curid     (curid),
        .cpu_clic_int_exit  (ex),
        .clic_cpu_int_hv    (hv_o),
        .clic_cpu_int_id    (id_o),
        .clic_cpu_int_il    (il_o),
        .clic_cpu_int_priv  (priv_o),
        .cpu_int_exit       (xo),
        .ctrl_kid_ack_int   (ack),
        .cpuif_exit_ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [7:0]  raw;
        logic        ex;
        logic [11:0] cur;
        logic [7:0]  il;
        logic        xo;
        int          ack_idx;   // -1: no ack bit expected
        logic        ovf;
    } vec_t;

    vec_t tbl [45];

    function automatic vec_t mk(input logic c, input logic [7:0] r, input logic e,
                                input logic [11:0] cu, input logic [7:0] l,
                                input logic x, input int a, input logic o);
        vec_t v;
        v.ce = c; v.raw = r; v.ex = e; v.cur = cu;
        v.il = l; v.xo = x; v.ack_idx = a; v.ovf = o;
        return v;
    endfunction

    function automatic logic [63:0] onehot(input int idx);
        logic [63:0] one;
        one = 64'd1;
        if (idx >= 0 && idx < NSRC) begin
            return one << idx;
        end else begin
            return 64'd0;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state: queue of pending exit IDs plus three flags.
    int q[$];
    bit m_sh;
    bit m_ie;
    bit m_ovf;

    initial begin
        logic [7:0]  e_il;
        logic [63:0] e_ack;

        // ratio 4, level appears on an edge cycle
        tbl[0]  = mk(0, 0, 0, 0,   0, 0, -1, 0);
        tbl[1]  = mk(0, 0, 0, 0,   0, 0, -1, 0);
        tbl[2]  = mk(0, 0, 0, 0,   0, 0, -1, 0);
        tbl[3]  = mk(1, 3, 0, 0,   0, 0, -1, 0);
        tbl[4]  = mk(0, 3, 0, 0,   3, 0, -1, 0);
        tbl[5]  = mk(0, 3, 0, 0,   3, 0, -1, 0);
        tbl[6]  = mk(0, 3, 0, 0,   3, 0, -1, 0);
        tbl[7]  = mk(1, 3, 0, 0,   3, 0, -1, 0);
        tbl[8]  = mk(0, 3, 0, 0,   3, 0, -1, 0);
        // exit id 5 two cycles before an edge
        tbl[9]  = mk(0, 3, 1, 5,   0, 0, -1, 0);
        tbl[10] = mk(0, 3, 0, 0,   0, 1,  5, 0);
        tbl[11] = mk(1, 3, 0, 0,   0, 1,  5, 0);
        tbl[12] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[13] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[14] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[15] = mk(1, 3, 0, 0,   0, 0, -1, 0);
        tbl[16] = mk(0, 3, 0, 0,   3, 0, -1, 0);
        // exits 7 then 9 in one period
        tbl[17] = mk(0, 3, 1, 7,   0, 0, -1, 0);
        tbl[18] = mk(0, 3, 1, 9,   0, 1,  7, 0);
        tbl[19] = mk(1, 3, 0, 0,   0, 1,  7, 0);
        tbl[20] = mk(0, 3, 0, 0,   0, 1,  9, 0);
        tbl[21] = mk(0, 3, 0, 0,   0, 1,  9, 0);
        tbl[22] = mk(0, 3, 0, 0,   0, 1,  9, 0);
        tbl[23] = mk(1, 3, 0, 0,   0, 1,  9, 0);
        tbl[24] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[25] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[26] = mk(0, 3, 0, 0,   0, 0, -1, 0);
        tbl[27] = mk(1, 3, 0, 0,   0, 0, -1, 0);
        // three exits in one period: id 3 dropped
        tbl[28] = mk(0, 3, 1, 1,   0, 0, -1, 0);
        tbl[29] = mk(0, 3, 1, 2,   0, 1,  1, 0);
        tbl[30] = mk(0, 3, 1, 3,   0, 1,  1, 0);
        tbl[31] = mk(1, 3, 0, 0,   0, 1,  1, 1);
        tbl[32] = mk(0, 3, 0, 0,   0, 1,  2, 1);
        tbl[33] = mk(0, 3, 0, 0,   0, 1,  2, 1);
        tbl[34] = mk(0, 3, 0, 0,   0, 1,  2, 1);
        tbl[35] = mk(1, 3, 0, 0,   0, 1,  2, 1);
        tbl[36] = mk(0, 3, 0, 0,   0, 0, -1, 1);
        // out-of-range exit id 200
        tbl[37] = mk(0, 3, 1, 200, 0, 0, -1, 1);
        tbl[38] = mk(0, 3, 0, 0,   0, 1, -1, 1);
        tbl[39] = mk(1, 3, 0, 0,   0, 1, -1, 1);
        tbl[40] = mk(0, 3, 0, 0,   0, 0, -1, 1);
        tbl[41] = mk(0, 3, 0, 0,   0, 0, -1, 1);
        tbl[42] = mk(0, 3, 0, 0,   0, 0, -1, 1);
        tbl[43] = mk(1, 3, 0, 0,   0, 0, -1, 1);
        tbl[44] = mk(0, 3, 0, 0,   3, 0, -1, 1);

        cpurst_b = 1'b0; scan_en = 1'b0; ce = 1'b0; hv_i = 1'b0; id_i = 12'd0;
        raw = 8'd0; priv_i = 2'd0; curid = 12'd0; ex = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_il",   64'(il_o), 64'd0);
        chk("rst_exit", 64'(xo),   64'd0);
        chk("rst_ack",  ack,       64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        cpurst_b = 1'b1;

        // directed table
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            ce = tbl[i].ce; raw = tbl[i].raw; ex = tbl[i].ex; curid = tbl[i].cur;
            #1;
            chk($sformatf("tbl%0d_il", i),   64'(il_o), 64'(tbl[i].il));
            chk($sformatf("tbl%0d_exit", i), 64'(xo),   64'(tbl[i].xo));
            chk($sformatf("tbl%0d_ack", i),  ack,       onehot(tbl[i].ack_idx));
            chk($sformatf("tbl%0d_ovf", i),  64'(ovf),  64'(tbl[i].ovf));
        end

        // reset while two exits are queued
        @(negedge clk); ce = 1'b0; raw = 8'd0; ex = 1'b1; curid = 12'd4;
        @(negedge clk); ex = 1'b1; curid = 12'd6;
        @(negedge clk); ex = 1'b0; #1;
        chk("preq_exit", 64'(xo), 64'd1);
        chk("preq_ack",  ack,     onehot(4));
        cpurst_b = 1'b0;
        #1;
        chk("midrst_exit", 64'(xo),   64'd0);
        chk("midrst_ack",  ack,       64'd0);
        chk("midrst_ovf",  64'(ovf),  64'd0);
        chk("midrst_il",   64'(il_o), 64'd0);
        @(negedge clk); cpurst_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ce = (i % 4 == 3);
            #1;
            chk("postrst_exit", 64'(xo), 64'd0);
            chk("postrst_ack",  ack,     64'd0);
        end

        // randomized phase against the reference model
        q.delete(); m_sh = 1'b0; m_ie = 1'b0; m_ovf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bit popped;
            @(negedge clk);
            ce     = ($urandom_range(0, 3) == 0);
            ex     = ($urandom_range(0, 4) == 0);
            curid  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(64, 4095))
                                                 : 12'($urandom_range(0, 63));
            raw    = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            hv_i   = 1'($urandom_range(0, 1));
            id_i   = 12'($urandom_range(0, 4095));
            priv_i = 2'($urandom_range(0, 3));
            #1;
            if ((q.size() == 0) && !m_sh && !ex && (!ce || m_ie)) begin
                e_il = raw;
            end else begin
                e_il = 8'd0;
            end
            e_ack = (q.size() != 0) ? onehot(q[0]) : 64'd0;
            chk("rnd_il",   64'(il_o),   64'(e_il));
            chk("rnd_exit", 64'(xo),     64'(q.size() != 0));
            chk("rnd_ack",  ack,         e_ack);
            chk("rnd_ovf",  64'(ovf),    64'(m_ovf));
            chk("rnd_hv",   64'(hv_o),   64'(hv_i));
            chk("rnd_id",   64'(id_o),   64'(id_i));
            chk("rnd_priv", 64'(priv_o), 64'(priv_i));
            // state after this cycle's clock edge
            popped = ce && (q.size() != 0);
            if (popped) void'(q.pop_front());
            if (ex) begin
                if (q.size() < DEPTH) q.push_back(int'(curid));
                else m_ovf = 1'b1;
            end
            if (popped && q.size() == 0) m_sh = 1'b1;
            else if (ce) m_sh = 1'b0;
            m_ie = ex ? 1'b0 : (e_il != 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
